// File: rtl/ld_cell_a2d.sv
// Load-cell A2D sampler: SPI master that periodically reads the left and
// right load cells from an 8-channel A2D. Each reading takes a 3-frame round,
// and both results are published together with a one-clock valid pulse.
module ld_cell_a2d #(
    parameter bit         fast_sim = 1'b0,
    parameter logic [2:0] LFT_CH   = 3'd0,
    parameter logic [2:0] RGHT_CH  = 3'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MISO,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic        ld_vld,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FRONT = 3'd1,
        SHIFT = 3'd2,
        BACK  = 3'd3,
        GAP   = 3'd4
    } state_t;

    // SCLK low phase starts at 0; preloading 22 gives a 10-clk front porch
    localparam logic [4:0] DIV_PRELOAD = 5'b10110;
    localparam logic [4:0] DIV_TX_EDGE = 5'b11111;
    localparam logic [4:0] DIV_RX_EDGE = 5'b01111;

    state_t      state, nxt_state;
    logic [19:0] timer;
    logic [4:0]  div;
    logic [3:0]  bit_cnt;
    logic [1:0]  trans_cnt;
    logic        gap_cnt;
    logic        upd;
    logic [15:0] tx_sr;
    logic [11:0] rx_sr;
    logic [11:0] shadow_lft;
    logic [2:0]  cmd_ch;

    logic timer_full;
    logic load_frame;
    logic shft;
    logic smpl;
    logic capture;

    assign timer_full = fast_sim ? (&timer[9:0]) : (&timer);

    // First frame of a round asks for the left channel; later frames ask for right
    assign cmd_ch = (state == IDLE) ? LFT_CH : RGHT_CH;

    // Chip select gates MOSI so the line rests low between frames
    assign MOSI = tx_sr[15] & ~SS_n;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt_state;
    end

    // Next-state decode plus per-cycle strobes and pin levels
    always_comb begin
        nxt_state  = state;
        load_frame = 1'b0;
        shft       = 1'b0;
        smpl       = 1'b0;
        capture    = 1'b0;
        SS_n       = 1'b0;
        SCLK       = 1'b1;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                SS_n = 1'b1;
                busy = 1'b0;
                if (timer_full) begin
                    nxt_state  = FRONT;
                    load_frame = 1'b1;
                end
            end
            FRONT: begin
                SCLK = div[4];
                if (div == DIV_TX_EDGE) nxt_state = SHIFT;
            end
            SHIFT: begin
                SCLK = div[4];
                shft = (div == DIV_TX_EDGE);
                if (div == DIV_RX_EDGE) begin
                    smpl = 1'b1;
                    if (bit_cnt == 4'd15) nxt_state = BACK;
                end
            end
            BACK: begin
                capture   = 1'b1;
                nxt_state = GAP;
            end
            GAP: begin
                SS_n = 1'b1;
                if (gap_cnt) begin
                    if (trans_cnt == 2'd2) begin
                        nxt_state = IDLE;
                    end else begin
                        nxt_state  = FRONT;
                        load_frame = 1'b1;
                    end
                end
            end
            default: begin
                nxt_state = IDLE;
                SS_n      = 1'b1;
                busy      = 1'b0;
            end
        endcase
    end

    // Sample timer runs only while idle, so a round can never be re-triggered mid-flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer <= '0;
        end else if (state == IDLE) begin
            if (timer_full) timer <= '0;
            else            timer <= timer + 20'd1;
        end
    end

    // SCLK divider, bit counter, frame counter and inter-frame gap counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div       <= '0;
            bit_cnt   <= '0;
            trans_cnt <= '0;
            gap_cnt   <= 1'b0;
        end else begin
            if (load_frame)                            div <= DIV_PRELOAD;
            else if (state == FRONT || state == SHIFT) div <= div + 5'd1;

            if (load_frame) bit_cnt <= '0;
            else if (smpl)  bit_cnt <= bit_cnt + 4'd1;

            if (state == IDLE)   trans_cnt <= '0;
            else if (load_frame) trans_cnt <= trans_cnt + 2'd1;

            gap_cnt <= (state == GAP) && !gap_cnt;
        end
    end

    // Command and response shift registers plus the left-result holding register
    always_ff @(posedge clk) begin
        if (load_frame)  tx_sr <= {2'b00, cmd_ch, 11'h000};
        else if (shft)   tx_sr <= {tx_sr[14:0], 1'b0};

        if (smpl)        rx_sr <= {rx_sr[10:0], MISO};

        if (capture && trans_cnt == 2'd1) shadow_lft <= rx_sr;
    end

    // Publish both readings in one clock after frame 3, then pulse valid a clock later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lft_ld  <= '0;
            rght_ld <= '0;
            upd     <= 1'b0;
            ld_vld  <= 1'b0;
        end else begin
            upd    <= capture && (trans_cnt == 2'd2);
            ld_vld <= upd;
            if (capture && trans_cnt == 2'd2) begin
                lft_ld  <= shadow_lft;
                rght_ld <= rx_sr;
            end
        end
    end

endmodule
